// File: rtl/ccff_loader.sv
// Config-chain loader: serialises valid/ready words MSB-first onto ccff_head with a gated shift enable; one FETCH cycle per word plus one cycle per bit.
// Stalls (prog_clk_en low, ccff_head held) while din_valid is low; optional CRC-8 trailer check under CCFF_CRC_EN.
module ccff_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 24
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  start,
    input  logic                  din_valid,
    input  logic [WORD_WIDTH-1:0] din,
    output logic                  din_ready,
    output logic                  ccff_head,
    output logic                  prog_clk_en,
    output logic                  busy,
    output logic                  done,
    output logic                  crc_err
);
    localparam int CW = $clog2(CHAIN_LENGTH + 1);
    localparam int IW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CHAIN_LENGTH);
    localparam logic [IW-1:0] TOP_IDX  = IW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
`ifdef CCFF_CRC_EN
        CHECK,
`endif
        DONE
    } state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] sreg;
    logic [WORD_WIDTH-1:0] sreg_shl;
    logic [IW-1:0]         idx;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;

    assign sreg_shl = sreg << 1;
    assign cnt_inc  = cnt + CW'(1);

`ifdef CCFF_CRC_EN
    assign din_ready = (state == FETCH) || (state == CHECK);
`else
    assign din_ready = (state == FETCH);
`endif

    // sreg[MSB] is always the bit currently presented on ccff_head.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state       <= IDLE;
            sreg        <= '0;
            idx         <= '0;
            cnt         <= '0;
            ccff_head   <= 1'b0;
            prog_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cnt   <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (din_valid) begin
                        sreg        <= din;
                        idx         <= TOP_IDX;
                        ccff_head   <= din[WORD_WIDTH-1];
                        prog_clk_en <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == LAST_CNT) begin
                        // Remaining low bits of a partial last word are dropped here.
                        prog_clk_en <= 1'b0;
`ifdef CCFF_CRC_EN
                        state       <= CHECK;
`else
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
`endif
                    end else if (idx == '0) begin
                        prog_clk_en <= 1'b0;
                        state       <= FETCH;
                    end else begin
                        sreg      <= sreg_shl;
                        ccff_head <= sreg_shl[WORD_WIDTH-1];
                        idx       <= idx - IW'(1);
                    end
                end
`ifdef CCFF_CRC_EN
                CHECK: begin
                    if (din_valid) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CCFF_CRC_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // CRC follows exactly the bits the chain captures.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            crc     <= 8'h00;
            crc_err <= 1'b0;
        end else if ((state == IDLE || state == DONE) && start) begin
            crc     <= 8'h00;
            crc_err <= 1'b0;
        end else if (state == SHIFT && prog_clk_en) begin
            crc <= crc8_step(crc, ccff_head);
        end else if (state == CHECK && din_valid) begin
            crc_err <= (din[7:0] != crc);
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (24-bit and 20-bit chains) checked against a word-level stream model.
module tb_ccff_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       prog_reset, start0, start1, din_valid;
    logic [7:0] din;
    logic       rdy0, head0, pce0, busy0, done0, crc0;
    logic       rdy1, head1, pce1, busy1, done1, crc1;

    ccff_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(24)) u0 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start0), .din_valid(din_valid),
        .din(din), .din_ready(rdy0), .ccff_head(head0), .prog_clk_en(pce0),
        .busy(busy0), .done(done0), .crc_err(crc0));

    ccff_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20)) u1 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start1), .din_valid(din_valid),
        .din(din), .din_ready(rdy1), .ccff_head(head1), .prog_clk_en(pce1),
        .busy(busy1), .done(done1), .crc_err(crc1));

`ifdef CCFF_CRC_EN
    localparam int CRC_EXTRA = 1;
`else
    localparam int CRC_EXTRA = 0;
`endif

    int   cur_sel;
    logic o_rdy, o_head, o_pce, o_busy, o_done, o_crc;
    always_comb begin
        if (cur_sel == 1) {o_rdy, o_head, o_pce, o_busy, o_done, o_crc} = {rdy1, head1, pce1, busy1, done1, crc1};
        else              {o_rdy, o_head, o_pce, o_busy, o_done, o_crc} = {rdy0, head0, pce0, busy0, done0, crc0};
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  tx_words[$];
    logic [63:0] got_vec;
    int          r_done, r_pce, r_runs, r_gaps, r_headbad, r_busybad, r_consumed;
    logic [5:0]  r_rst_outs;

    // Expected chain image: data words concatenated MSB-first, truncated to the chain length.
    function automatic logic [63:0] exp_vec(input int cl);
        logic [63:0] v;
        int nd;
        v  = '0;
        nd = (cl + 7) / 8;
        for (int i = 0; i < nd; i++) v = (v << 8) | 64'(tx_words[i]);
        return v >> (nd * 8 - cl);
    endfunction

    // Byte-wise CRC-8 (poly 0x07, init 0) over the first nd words.
    function automatic logic [7:0] crc_model(input int nd);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < nd; i++) begin
            c = c ^ tx_words[i];
            for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic run_load(input int sel, input int gap_idx, input int gap_len,
                            input int rand_pct, input int pulse_at, input int reset_at);
        int   wi, gap_left;
        logic hs, prev_pce, last_bit, stall;
        cur_sel = sel;
        got_vec = '0;
        {r_pce, r_runs, r_gaps, r_headbad, r_busybad} = '0;
        r_done = -1; r_rst_outs = '1;
        wi = 0; gap_left = gap_len; hs = 1'b0; prev_pce = 1'b0;
        din_valid = 1'b0;
        #0 last_bit = o_head;
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            if (hs) wi++;
            if (o_pce) begin
                got_vec = {got_vec[62:0], o_head};
                r_pce++;
                if (!prev_pce) r_runs++;
                last_bit = o_head;
            end
            prev_pce = o_pce;
            if (reset_at > 0 && r_pce == reset_at) begin
                prog_reset = 1'b1;
                #1 r_rst_outs = {o_rdy, o_head, o_pce, o_busy, o_done, o_crc};
                break;
            end
            if (o_done) begin
                r_done = cyc;
                if (o_busy) r_busybad++;
                break;
            end
            if (!o_busy) r_busybad++;
            if (cyc == pulse_at) begin
                if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
            end
            din_valid = 1'b0;
            if (wi < tx_words.size()) begin
                din   = tx_words[wi];
                stall = 1'b0;
                if (o_rdy && wi == gap_idx && gap_left > 0) begin
                    gap_left--; stall = 1'b1;
                end else if (o_rdy && int'($urandom_range(99)) < rand_pct) begin
                    stall = 1'b1;
                end
                if (stall) begin
                    r_gaps++;
                    if (o_pce || o_head !== last_bit) r_headbad++;
                end else begin
                    din_valid = 1'b1;
                end
            end
            hs = din_valid && o_rdy;
        end
        r_consumed = wi;
        din_valid  = 1'b0;
    endtask

    task automatic test_reset();
        prog_reset = 1'b1; start0 = 1'b0; start1 = 1'b0; din_valid = 1'b0; din = '0; cur_sel = 0;
        #12;
        n_checks++; if (rdy0 !== 1'b0)  begin n_fail++; $display("FAIL reset_din_ready: got %b expected 0", rdy0); end
        n_checks++; if (head0 !== 1'b0) begin n_fail++; $display("FAIL reset_ccff_head: got %b expected 0", head0); end
        n_checks++; if (pce0 !== 1'b0)  begin n_fail++; $display("FAIL reset_prog_clk_en: got %b expected 0", pce0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done0); end
        n_checks++; if (crc0 !== 1'b0)  begin n_fail++; $display("FAIL reset_crc_err: got %b expected 0", crc0); end
        n_checks++;
        if ({rdy1, head1, pce1, busy1, done1, crc1} !== 6'b0) begin
            n_fail++; $display("FAIL reset_u1_outputs: got %b expected 000000", {rdy1, head1, pce1, busy1, done1, crc1});
        end
        @(negedge clk); prog_reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (rdy0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got rdy=%b busy=%b expected 0 0", rdy0, busy0); end
    endtask

    task automatic load_basic_words();
        tx_words = '{8'hA5, 8'h3C, 8'hF0};
        if (CRC_EXTRA == 1) tx_words.push_back(crc_model(3));
    endtask

    task automatic test_basic();
        load_basic_words();
        run_load(0, -1, 0, 0, 0, 0);
        n_checks++; if (got_vec !== 64'hA53CF0) begin n_fail++; $display("FAIL basic_bits: got %h expected %h", got_vec, 64'hA53CF0); end
        n_checks++; if (r_pce !== 24) begin n_fail++; $display("FAIL basic_pce_cycles: got %0d expected 24", r_pce); end
        n_checks++; if (r_runs !== 3) begin n_fail++; $display("FAIL basic_pce_runs: got %0d expected 3", r_runs); end
        n_checks++; if (r_done !== 28 + CRC_EXTRA) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", r_done, 28 + CRC_EXTRA); end
        n_checks++; if (r_busybad !== 0) begin n_fail++; $display("FAIL basic_busy: got %0d bad cycles expected 0", r_busybad); end
        n_checks++; if (r_consumed !== tx_words.size()) begin n_fail++; $display("FAIL basic_words_taken: got %0d expected %0d", r_consumed, tx_words.size()); end
        n_checks++; if (o_crc !== 1'b0) begin n_fail++; $display("FAIL basic_crc_err: got %b expected 0", o_crc); end
    endtask

    task automatic test_gap();
        load_basic_words();
        run_load(0, 1, 5, 0, 0, 0);
        n_checks++; if (got_vec !== 64'hA53CF0) begin n_fail++; $display("FAIL gap_bits: got %h expected %h", got_vec, 64'hA53CF0); end
        n_checks++; if (r_gaps !== 5) begin n_fail++; $display("FAIL gap_len: got %0d expected 5", r_gaps); end
        n_checks++; if (r_headbad !== 0) begin n_fail++; $display("FAIL gap_chain_hold: got %0d unstable cycles expected 0", r_headbad); end
        n_checks++; if (r_done !== 33 + CRC_EXTRA) begin n_fail++; $display("FAIL gap_done_cycle: got %0d expected %0d", r_done, 33 + CRC_EXTRA); end
    endtask

    task automatic test_partial();
        tx_words = '{8'hFF, 8'h00, 8'hBF};
        if (CRC_EXTRA == 1) tx_words.push_back(8'h00);
        run_load(1, -1, 0, 0, 0, 0);
        n_checks++; if (got_vec !== 64'hFF00B) begin n_fail++; $display("FAIL partial_bits: got %h expected %h", got_vec, 64'hFF00B); end
        n_checks++; if (r_pce !== 20) begin n_fail++; $display("FAIL partial_pce_cycles: got %0d expected 20", r_pce); end
        n_checks++; if (r_runs !== 3) begin n_fail++; $display("FAIL partial_pce_runs: got %0d expected 3", r_runs); end
        n_checks++; if (r_done !== 24 + CRC_EXTRA) begin n_fail++; $display("FAIL partial_done_cycle: got %0d expected %0d", r_done, 24 + CRC_EXTRA); end
    endtask

    task automatic test_reset_mid_load();
        load_basic_words();
        run_load(0, -1, 0, 0, 0, 12);
        n_checks++; if (r_pce !== 12) begin n_fail++; $display("FAIL midreset_reached: got %0d shift cycles expected 12", r_pce); end
        n_checks++; if (r_rst_outs !== 6'b0) begin n_fail++; $display("FAIL midreset_outputs: got %b expected 000000", r_rst_outs); end
        @(negedge clk); prog_reset = 1'b0;
        @(posedge clk); #1;
        run_load(0, -1, 0, 0, 0, 0);
        n_checks++; if (got_vec !== 64'hA53CF0) begin n_fail++; $display("FAIL midreset_reload_bits: got %h expected %h", got_vec, 64'hA53CF0); end
        n_checks++; if (r_done !== 28 + CRC_EXTRA) begin n_fail++; $display("FAIL midreset_reload_done: got %0d expected %0d", r_done, 28 + CRC_EXTRA); end
    endtask

    task automatic test_start_while_busy();
        int pulses[2] = '{5, 10};
        foreach (pulses[p]) begin
            load_basic_words();
            run_load(0, -1, 0, 0, pulses[p], 0);
            n_checks++; if (got_vec !== 64'hA53CF0) begin n_fail++; $display("FAIL busystart_bits_at_%0d: got %h expected %h", pulses[p], got_vec, 64'hA53CF0); end
            n_checks++; if (r_pce !== 24) begin n_fail++; $display("FAIL busystart_count_at_%0d: got %0d expected 24", pulses[p], r_pce); end
            n_checks++; if (r_done !== 28 + CRC_EXTRA) begin n_fail++; $display("FAIL busystart_done_at_%0d: got %0d expected %0d", pulses[p], r_done, 28 + CRC_EXTRA); end
        end
    endtask

`ifdef CCFF_CRC_EN
    task automatic test_crc();
        logic [7:0] trailer[2] = '{8'h07, 8'h06};
        logic       exp_err[2] = '{1'b0, 1'b1};
        foreach (trailer[t]) begin
            tx_words = '{8'h00, 8'h00, 8'h01};
            tx_words.push_back(trailer[t]);
            run_load(0, -1, 0, 0, 0, 0);
            n_checks++; if (o_crc !== exp_err[t]) begin n_fail++; $display("FAIL crc_err_%h: got %b expected %b", trailer[t], o_crc, exp_err[t]); end
            n_checks++; if (r_done !== 29) begin n_fail++; $display("FAIL crc_done_%h: got %0d expected 29", trailer[t], r_done); end
        end
    endtask
`endif

    task automatic test_random();
        int         sel, cl, nd, exp_done;
        logic [7:0] flip;
        for (int it = 0; it < 16; it++) begin
            sel = int'($urandom_range(1));
            cl  = (sel == 1) ? 20 : 24;
            nd  = (cl + 7) / 8;
            tx_words.delete();
            for (int i = 0; i < nd; i++) tx_words.push_back(8'($urandom));
            flip = ($urandom_range(1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (CRC_EXTRA == 1) tx_words.push_back((sel == 0) ? (crc_model(nd) ^ flip) : 8'($urandom));
            run_load(sel, -1, 0, 30, 0, 0);
            exp_done = 1 + cl + nd + r_gaps + CRC_EXTRA;
            n_checks++; if (got_vec !== exp_vec(cl)) begin n_fail++; $display("FAIL rand%0d_bits: got %h expected %h", it, got_vec, exp_vec(cl)); end
            n_checks++; if (r_pce !== cl) begin n_fail++; $display("FAIL rand%0d_pce: got %0d expected %0d", it, r_pce, cl); end
            n_checks++; if (r_done !== exp_done) begin n_fail++; $display("FAIL rand%0d_done: got %0d expected %0d", it, r_done, exp_done); end
            n_checks++; if (r_headbad !== 0) begin n_fail++; $display("FAIL rand%0d_stall_hold: got %0d expected 0", it, r_headbad); end
            if (CRC_EXTRA == 0 || sel == 0) begin
                n_checks++;
                if (o_crc !== (flip != 8'h00 && CRC_EXTRA == 1)) begin
                    n_fail++; $display("FAIL rand%0d_crc_err: got %b expected %b", it, o_crc, (flip != 8'h00 && CRC_EXTRA == 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_partial();
        test_reset_mid_load();
        test_start_while_busy();
`ifdef CCFF_CRC_EN
        test_crc();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
